// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick timeout timer.
//   ch_state_t    : per-channel state encoding (IDLE = 0, RUN = 1)
//   DEF_NUM_CH    : default number of channels
//   DEF_CNT_W     : default width of the limit and count fields
package tick_timer_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/tick_timer_ch.sv
// One timer channel. It counts shared timebase ticks up to a latched limit,
// then pulses timeout for one clk. It either reloads (periodic) or returns to
// IDLE (one-shot).
//
// Ports
//   clk, rst    : clock; synchronous active-low reset
//   tick_in     : shared timebase enable, one clk wide
//   start       : start/restart request (level, sampled each cycle)
//   stop        : abort request; wins over start
//   periodic    : mode captured with start (1 = auto-reload)
//   limit       : terminal tick count captured with start
//   timeout     : one-clk expiry pulse (registered)
//   busy        : channel is in RUN
//   err         : one-clk pulse, start rejected because limit was zero
//   count       : current tick count (registered)
//   state       : FSM state, exposed for debug and checkers
//
// Handshake: there is no valid/ready pair here. start/stop/tick_in are
// single-cycle qualifiers sampled on every rising clk. All outputs update on
// the following edge. There is no backpressure.
module tick_timer_ch
  import tick_timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] limit,
  output logic             timeout,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] count,
  output ch_state_t        state
);

  logic [CNT_W-1:0] lim_q;
  logic             per_q;
  logic             limit_ok;

  assign limit_ok = (limit != '0);
  assign busy     = (state == CH_RUN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CH_IDLE;
      lim_q   <= '0;
      per_q   <= 1'b0;
      count   <= '0;
      timeout <= 1'b0;
      err     <= 1'b0;
    end else begin
      // Both pulses are one clk wide unless they are re-asserted below.
      timeout <= 1'b0;
      err     <= 1'b0;
      case (state)
        CH_IDLE: begin
          // stop in IDLE does nothing, but it still suppresses a start.
          if (start && !stop) begin
            if (limit_ok) begin
              state <= CH_RUN;
              lim_q <= limit;
              per_q <= periodic;
              count <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        CH_RUN: begin
          if (stop) begin
            // Abort wins over an expiry in the same cycle.
            state <= CH_IDLE;
            count <= '0;
          end else if (start && limit_ok) begin
            // Restart: relatch the limit and mode, and ignore this cycle's tick.
            lim_q <= limit;
            per_q <= periodic;
            count <= '0;
          end else begin
            // A rejected restart leaves the running count untouched.
            if (start) err <= 1'b1;
            if (tick_in) begin
              // Comparing against limit-1 means count never reaches the limit.
              // A maximum limit therefore cannot wrap the counter.
              if (count == lim_q - CNT_W'(1)) begin
                count   <= '0;
                timeout <= 1'b1;
                if (!per_q) state <= CH_IDLE;
              end else begin
                count <= count + CNT_W'(1);
              end
            end
          end
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tick_timeout_timer.sv
// A bank of NUM_CH independent tick-driven timeout timers sharing a single
// timebase. This level only slices the input buses and concatenates the
// output buses. All state and outputs are registered in tick_timer_ch.
//
// Ports
//   clk, rst   : clock; synchronous active-low reset
//   tick_in    : shared timebase enable
//   start      : [NUM_CH] start/restart per channel
//   stop       : [NUM_CH] abort per channel
//   periodic   : [NUM_CH] mode per channel (1 = auto-reload)
//   limit      : [NUM_CH*CNT_W] terminal count; channel i at [i*CNT_W +: CNT_W]
//   timeout    : [NUM_CH] one-clk expiry pulses
//   busy       : [NUM_CH] channel in RUN
//   count      : [NUM_CH*CNT_W] current counts
//   err        : [NUM_CH] one-clk zero-limit rejection pulses
//   dbg_state  : [NUM_CH] per-channel FSM state (IDLE = 0, RUN = 1)
module tick_timeout_timer
  import tick_timer_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_in,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] limit,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       err,
  output logic [NUM_CH-1:0]       dbg_state
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_t st;

    tick_timer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick_in  (tick_in),
      .start    (start[g]),
      .stop     (stop[g]),
      .periodic (periodic[g]),
      .limit    (limit[g*CNT_W +: CNT_W]),
      .timeout  (timeout[g]),
      .busy     (busy[g]),
      .err      (err[g]),
      .count    (count[g*CNT_W +: CNT_W]),
      .state    (st)
    );

    assign dbg_state[g] = (st == CH_RUN);
  end

endmodule

// File: tb/tb_tick_timeout_timer.sv
module tb_tick_timeout_timer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int W      = 3 * NUM_CH + NUM_CH * CNT_W;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    tick_in = 1'b0;
  logic [NUM_CH-1:0]       start = '0;
  logic [NUM_CH-1:0]       stop = '0;
  logic [NUM_CH-1:0]       periodic = '0;
  logic [NUM_CH*CNT_W-1:0] limit = '0;
  logic [NUM_CH-1:0]       timeout;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       err;
  logic [NUM_CH-1:0]       dbg_state;

  always #5 clk = ~clk;

  tick_timeout_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .limit     (limit),
    .timeout   (timeout),
    .busy      (busy),
    .count     (count),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: each channel counts the ticks it has seen since the
  // last (re)load. It expires when that number reaches the loaded period.
  int m_run[NUM_CH];
  int m_per[NUM_CH];
  int m_lim[NUM_CH];
  int m_ticks[NUM_CH];

  function automatic logic [W-1:0] model_step();
    logic [NUM_CH-1:0]       to, bz, er;
    logic [NUM_CH*CNT_W-1:0] cn;
    int                      lim_in;
    to = '0; er = '0; bz = '0; cn = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lim_in = int'(limit[i*CNT_W +: CNT_W]);
      if (!rst) begin
        m_run[i] = 0; m_ticks[i] = 0; m_lim[i] = 0; m_per[i] = 0;
      end else if (stop[i]) begin
        if (m_run[i] != 0) begin m_run[i] = 0; m_ticks[i] = 0; end
      end else if (start[i] && lim_in != 0) begin
        m_run[i] = 1; m_lim[i] = lim_in; m_per[i] = int'(periodic[i]); m_ticks[i] = 0;
      end else begin
        if (start[i]) er[i] = 1'b1;
        if (m_run[i] != 0 && tick_in) begin
          m_ticks[i]++;
          if (m_ticks[i] == m_lim[i]) begin
            m_ticks[i] = 0;
            to[i] = 1'b1;
            if (m_per[i] == 0) m_run[i] = 0;
          end
        end
      end
      bz[i] = (m_run[i] != 0);
      cn[i*CNT_W +: CNT_W] = CNT_W'(m_ticks[i]);
    end
    return {to, bz, er, cn};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: the model predicts from the current inputs, the DUT clocks,
  // and the outputs are compared 1 time unit after the edge.
  task automatic cyc(input string tag);
    logic [W-1:0] e;
    exp_q.push_back(model_step());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".timeout"}, 64'(timeout), 64'(e[W-1 -: NUM_CH]));
    check({tag, ".busy"},    64'(busy),    64'(e[W-1-NUM_CH -: NUM_CH]));
    check({tag, ".err"},     64'(err),     64'(e[W-1-2*NUM_CH -: NUM_CH]));
    check({tag, ".count"},   64'(count),   64'(e[NUM_CH*CNT_W-1:0]));
    check({tag, ".dbg"},     64'(dbg_state), 64'(e[W-1-NUM_CH -: NUM_CH]));
  endtask

  task automatic set_lim(input int ch, input int lim, input logic per);
    limit[ch*CNT_W +: CNT_W] = CNT_W'(lim);
    periodic[ch] = per;
  endtask

  task automatic do_start(input int ch, input int lim, input logic per, input string tag);
    set_lim(ch, lim, per);
    start[ch] = 1'b1;
    cyc(tag);
    start[ch] = 1'b0;
  endtask

  // n ticks, one every `gap` clocks
  task automatic ticks(input int n, input int gap, input string tag);
    for (int k = 0; k < n; k++) begin
      tick_in = 1'b1;
      cyc(tag);
      tick_in = 1'b0;
      for (int j = 1; j < gap; j++) cyc(tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset: outputs zero while held low.
    rst = 1'b0;
    start = '1; limit = '1; tick_in = 1'b1;
    cyc("reset0");
    cyc("reset1");
    start = '0; limit = '0; tick_in = 1'b0;
    rst = 1'b1;

    // One-shot limit 5, start on the first cycle out of reset, tick every 10.
    do_start(0, 5, 1'b0, "oneshot_start");
    ticks(5, 10, "oneshot");
    check("oneshot_idle_after", 64'(busy[0]), 64'd0);

    // Periodic limit 3, 10 ticks: expiries after ticks 3, 6 and 9.
    do_start(1, 3, 1'b1, "periodic_start");
    ticks(10, 3, "periodic");
    check("periodic_busy", 64'(busy[1]), 64'd1);
    stop[1] = 1'b1; cyc("periodic_stop"); stop[1] = 1'b0;

    // Stop in the same cycle as the expiring 4th tick.
    do_start(2, 4, 1'b0, "stop_start");
    ticks(3, 2, "stop_pre");
    tick_in = 1'b1; stop[2] = 1'b1;
    cyc("stop_at_expiry");
    tick_in = 1'b0; stop[2] = 1'b0;
    check("stop_no_timeout", 64'(timeout[2]), 64'd0);
    check("stop_count", 64'(count[2*CNT_W +: CNT_W]), 64'd0);
    cyc("stop_after");

    // Restart at count 2 with a tick in the same cycle.
    do_start(3, 4, 1'b0, "restart_start");
    ticks(2, 2, "restart_pre");
    start[3] = 1'b1; tick_in = 1'b1;
    cyc("restart");
    start[3] = 1'b0; tick_in = 1'b0;
    check("restart_count", 64'(count[3*CNT_W +: CNT_W]), 64'd0);
    ticks(4, 2, "restart_post");

    // Zero limit is rejected; start with stop does nothing.
    do_start(0, 0, 1'b0, "zero_limit");
    check("zero_err", 64'(err[0]), 64'd1);
    cyc("zero_after");
    set_lim(0, 3, 1'b0);
    start[0] = 1'b1; stop[0] = 1'b1;
    cyc("start_stop");
    start[0] = 1'b0; stop[0] = 1'b0;
    check("start_stop_busy", 64'(busy[0]), 64'd0);

    // Maximum limit: the count must not wrap before expiring.
    do_start(1, 255, 1'b0, "max_start");
    ticks(256, 1, "max");

    // All four channels at limit 2, started together, expire together.
    for (int i = 0; i < NUM_CH; i++) set_lim(i, 2, 1'b1);
    start = '1; cyc("all_start"); start = '0;
    ticks(1, 2, "all");
    tick_in = 1'b1; cyc("all_expire"); tick_in = 1'b0;
    check("all_timeout", 64'(timeout), 64'hf);
    ticks(1, 1, "all_more");
    rst = 1'b0; cyc("mid_reset"); rst = 1'b1;
    check("mid_reset_busy", 64'(busy), 64'd0);
    cyc("post_reset");

    // Randomized traffic across all channels.
    for (int n = 0; n < 3000; n++) begin
      tick_in = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        start[i] = ($urandom_range(0, 15) == 0);
        stop[i]  = ($urandom_range(0, 39) == 0);
        periodic[i] = $urandom_range(0, 1);
        limit[i*CNT_W +: CNT_W] = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
      end
      rst = ($urandom_range(0, 299) != 0);
      cyc("rand");
    end
    rst = 1'b1; start = '0; stop = '0; tick_in = 1'b0;
    cyc("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_timeout_timer.md
TICK_TIMEOUT_TIMER -- requirements
Module: tick_timeout_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels, range 1..16.
REQ-002 Parameter CNT_W, default 8: width of each channel's limit and count fields, range 2..16.
REQ-003 clk  in  1  clock; all logic is rising-edge clk.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 tick_in  in  1  shared timebase enable, one cycle wide (e.g. 100 ms tick); asynchronous to nothing, sampled every clk.
REQ-006 start  in  NUM_CH  per-channel start/restart request, level sampled each cycle.
REQ-007 stop  in  NUM_CH  per-channel abort request.
REQ-008 periodic  in  NUM_CH  per-channel mode, sampled with start: 1 = auto-reload, 0 = one-shot.
REQ-009 limit  in  NUM_CH*CNT_W  per-channel terminal tick count; channel i uses bits [i*CNT_W +: CNT_W].
REQ-010 timeout  out  NUM_CH  per-channel expiry pulse, one clk wide.
REQ-011 busy  out  NUM_CH  channel i is in RUN.
REQ-012 count  out  NUM_CH*CNT_W  per-channel current tick count.
REQ-013 err  out  NUM_CH  one-clk pulse: start rejected because limit was zero.

Function
REQ-014 Each channel has states IDLE and RUN; busy[i] = (state == RUN).
REQ-015 IDLE + start[i] with limit_i != 0 -> RUN next cycle; latch limit_i and periodic[i]; count cleared to 0.
REQ-016 IDLE + start[i] with limit_i == 0 -> stay IDLE; err[i] pulses next cycle.
REQ-017 RUN + tick_in -> count increments by 1, unsigned, CNT_W wide.
REQ-018 Expiry: RUN, tick_in, and count == latched_limit-1 -> timeout[i] = 1 next cycle; count returns to 0 in the same cycle.
REQ-019 On expiry, one-shot returns to IDLE and periodic stays in RUN; the period is exactly latched_limit ticks.
REQ-020 Latency: timeout[i] rises one clk after the expiring tick_in cycle and stays high one clk only.
REQ-021 Changes to limit or periodic during RUN are ignored until the next start.
REQ-022 RUN + start[i] -> restart: relatch limit/mode and clear count; any tick_in in that cycle is ignored and no timeout is issued.
REQ-023 stop[i] in RUN -> IDLE next cycle; count cleared; no timeout, even when the same cycle would have expired.
REQ-024 start[i] and stop[i] together -> stop wins, in either state.
REQ-025 stop[i] in IDLE has no effect.
REQ-026 Channels are fully independent; simultaneous expiries on several channels all pulse in the same cycle.
REQ-027 With limit = 2^CNT_W-1 (maximum), count never wraps past limit-1.
REQ-028 count holds its value between ticks.

Reset
REQ-029 While rst == 0 at a clk edge, every channel goes to IDLE and every output is 0: busy, timeout, err, count.
REQ-030 Reset mid-RUN discards the latched limit and mode, and produces no timeout pulse.
REQ-031 The first start is accepted on the first cycle with rst == 1.

Structure
REQ-032 Shared package tick_timer_pkg holds the channel state encoding (IDLE = 0, RUN = 1) and the default parameter constants.
REQ-033 Sub-module tick_timer_ch implements one channel; it is instantiated NUM_CH times in a generate loop.
REQ-034 The top level only slices and concatenates buses; all outputs are registered inside tick_timer_ch.

Verification
REQ-035 One-shot, limit = 5, tick_in every 10 clk, start at cycle 0:
  - timeout pulses once, one clk after the 5th tick;
  - busy drops in the same cycle;
  - count goes 0,1,2,3,4,0.
REQ-036 Periodic, limit = 3, 10 ticks:
  - timeout after ticks 3, 6, 9;
  - busy stays 1 throughout.
REQ-037 limit = 4, stop asserted in the same cycle as the 4th tick:
  - no timeout;
  - busy = 0 and count = 0 next cycle.
REQ-038 Restart with start at count = 2 (limit = 4), with tick_in in that cycle:
  - count = 0;
  - timeout only after 4 further ticks.
REQ-039 start with limit = 0: err pulses for 1 clk, busy stays 0; start together with stop: busy stays 0.
REQ-040 NUM_CH = 4, all channels at limit = 2 started together: all four timeout bits pulse in the same cycle; then rst = 0 mid-RUN clears all outputs next clk.
